// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock controller for the 5-stage core.
// Covers the hazards operand forwarding cannot resolve: load-use
// dependencies, taken branches resolved in EX, and the multi-cycle
// multiplier occupying EX. It also keeps saturating statistics counters.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   id_ra/id_rb         source registers of the instruction in ID
//   id_use_a/id_use_b   ID instruction actually reads id_ra / id_rb
//   ex_rd               destination register of the instruction in EX
//   ex_mem_read         EX instruction is a load
//   ex_is_mul           EX instruction is a multiply (level)
//   ex_branch_taken     branch in EX resolved taken
//   pc_en/ifid_en/idex_en            stage enables
//   ifid_flush/idex_bubble/exmem_bubble  NOP insertion controls
//   mul_busy            high while the multiplier holds EX
//   stall_count         cycles with pc_en=0, saturating
//   flush_count         taken-branch flushes, saturating
// Control outputs are combinational (Mealy); only state, mul_cnt and the
// counters are registered.
module hazard_ctrl #(
  parameter int unsigned REG_W      = 4,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_is_mul,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned MC_W = $clog2(MUL_CYCLES) + 1;

  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MUL = 1'b1;

  localparam logic [MC_W-1:0]  MUL_LAST = MC_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [0:0]      state, state_nxt;
  logic [MC_W-1:0] mul_cnt, mul_cnt_nxt;
  logic            load_use;
  logic            flush_evt;

  // Register 0 is not special: the forwarding unit treats it as ordinary.
  assign load_use = ex_mem_read &&
                    ((id_use_a && (id_ra == ex_rd)) ||
                     (id_use_b && (id_rb == ex_rd)));

  // State and multiply-cycle registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  // Next-state and Mealy control outputs; reset forces idle outputs.
  always_comb begin
    state_nxt    = state;
    mul_cnt_nxt  = mul_cnt;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mul_busy     = 1'b0;
    flush_evt    = 1'b0;

    if (!rst) begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            // Branch wins: the younger instructions are wrong-path anyway.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_evt   = 1'b1;
          end else if (ex_is_mul) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            mul_cnt_nxt  = MC_W'(1);
            state_nxt    = MUL;
          end else if (load_use) begin
            // One-cycle bubble; the load reaches MEM and forwarding takes over.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MUL: begin
          mul_busy = 1'b1;
          if (mul_cnt == MUL_LAST) begin
            // Release cycle: result leaves EX with idle controls.
            mul_cnt_nxt = '0;
            state_nxt   = RUN;
          end else begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            mul_cnt_nxt  = mul_cnt + MC_W'(1);
          end
        end
        default: begin
          state_nxt   = RUN;
          mul_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_en && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush_evt && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control vectors are queued when
// stimulus is driven and popped/compared at the following falling edge.
module tb_hazard_ctrl;

  localparam int unsigned REG_W = 4;

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exmem_bubble, mul_busy}
  localparam logic [6:0] E_IDLE  = 7'b111_000_0;
  localparam logic [6:0] E_LU    = 7'b001_010_0;
  localparam logic [6:0] E_MENT  = 7'b000_001_0;
  localparam logic [6:0] E_MSTL  = 7'b000_001_1;
  localparam logic [6:0] E_MREL  = 7'b111_000_1;
  localparam logic [6:0] E_BR    = 7'b111_110_0;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_ra, id_rb, ex_rd;
  logic             id_use_a, id_use_b, ex_mem_read, ex_is_mul, ex_branch_taken;

  logic        pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exmem_bubble, mul_busy;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_mul_busy;
  logic [1:0]  s_stall_count, s_flush_count;

  int passed = 0;
  int total  = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  hazard_ctrl #(.REG_W(REG_W), .MUL_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_ra(id_ra), .id_rb(id_rb), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .mul_busy(mul_busy), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.REG_W(REG_W), .MUL_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_ra(id_ra), .id_rb(id_rb), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .exmem_bubble(s_exmem_bubble),
    .mul_busy(s_mul_busy), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_vec();
    return {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exmem_bubble, mul_busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_in(input logic mr, input logic [REG_W-1:0] rd,
                        input logic ua, input logic [REG_W-1:0] ra,
                        input logic ub, input logic [REG_W-1:0] rb,
                        input logic mul, input logic br);
    ex_mem_read = mr; ex_rd = rd;
    id_use_a = ua; id_ra = ra;
    id_use_b = ub; id_rb = rb;
    ex_is_mul = mul; ex_branch_taken = br;
  endtask

  // Queue the expectation, compare at the falling edge, then advance one cycle.
  task automatic step(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(ctl_vec()), 32'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset holds idle outputs even with every hazard input asserted.
    rst = 1'b1;
    set_in(1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0);
    #2;
    check("reset_outputs", 32'(ctl_vec()), 32'(E_IDLE));
    @(posedge clk);
    #1;
    check("reset_stall_cnt", 32'(stall_count), 32'd0);
    check("reset_flush_cnt", 32'(flush_count), 32'd0);
    idle_in();
    rst = 1'b0;

    // Load-use on port A, then the load moves on.
    set_in(1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    step("loaduse_a", E_LU);
    idle_in();
    step("loaduse_a_clear", E_IDLE);
    check("stall_cnt_lu", 32'(stall_count), 32'd1);

    // Load-use on port B, and register 0 as an ordinary register.
    set_in(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    step("loaduse_b", E_LU);
    set_in(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd7, 1'b0, 1'b0);
    step("loaduse_r0", E_LU);

    // Matching register but not actually read: no stall.
    set_in(1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0);
    step("no_false_stall", E_IDLE);
    check("stall_cnt_nofalse", 32'(stall_count), 32'd3);

    // Two back-to-back multiplies with ex_is_mul held high.
    set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    step("mul1_entry", E_MENT);
    step("mul1_stall2", E_MSTL);
    step("mul1_stall3", E_MSTL);
    step("mul1_release", E_MREL);
    check("stall_cnt_mul1", 32'(stall_count), 32'd6);
    step("mul2_entry", E_MENT);
    // Branch and load-use are ignored while the multiplier owns EX.
    set_in(1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b1);
    step("mul2_ignore_br", E_MSTL);
    set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    step("mul2_stall3", E_MSTL);
    idle_in();
    step("mul2_release", E_MREL);
    check("stall_cnt_mul2", 32'(stall_count), 32'd9);
    check("flush_cnt_mul", 32'(flush_count), 32'd0);
    step("after_mul_idle", E_IDLE);

    // Branch beats multiply and load-use in the same cycle.
    set_in(1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 4'd0, 1'b1, 1'b1);
    step("branch_prio", E_BR);
    check("flush_cnt_br", 32'(flush_count), 32'd1);
    idle_in();
    step("branch_no_mul", E_IDLE);
    check("stall_cnt_br", 32'(stall_count), 32'd9);

    // Asynchronous reset in the middle of a multiply.
    set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    step("mulr_entry", E_MENT);
    step("mulr_stall2", E_MSTL);
    check("mulr_stall3_pre", 32'(ctl_vec()), 32'(E_MSTL));
    rst = 1'b1;
    #1;
    check("async_rst_outputs", 32'(ctl_vec()), 32'(E_IDLE));
    check("async_rst_stall", 32'(stall_count), 32'd0);
    check("async_rst_flush", 32'(flush_count), 32'd0);
    @(posedge clk);
    #1;
    idle_in();
    rst = 1'b0;
    step("post_rst_idle", E_IDLE);
    step("post_rst_idle2", E_IDLE);
    check("post_rst_stall", 32'(stall_count), 32'd0);

    // Five load-use stalls: wide counter reaches 5, 2-bit counter sticks at 3.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 4'd9, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0);
      step("sat_loaduse", E_LU);
      idle_in();
      step("sat_idle", E_IDLE);
      if (i == 2) check("sat_cnt_at3", 32'(s_stall_count), 32'd3);
    end
    check("sat_cnt_stuck", 32'(s_stall_count), 32'd3);
    check("wide_cnt_5", 32'(stall_count), 32'd5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline interlock controller for the 5-stage core. It sits beside the operand forwarding unit and generates stage enables, flushes and bubbles. It covers the three cases forwarding cannot fix: load-use dependencies, taken branches resolved in EX, and the multi-cycle multiplier occupying EX. It also keeps saturating stall and flush statistics counters.

Parameters:
REG_W, 4, register address width
MUL_CYCLES, 4, total cycles a multiply occupies EX (legal range >= 2)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_ra  in  REG_W  source reg A of instruction in ID
id_rb  in  REG_W  source reg B of instruction in ID
id_use_a  in  1  ID instruction reads id_ra
id_use_b  in  1  ID instruction reads id_rb
ex_rd  in  REG_W  destination reg of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_is_mul  in  1  EX instruction is a multiply (level)
ex_branch_taken  in  1  branch in EX resolved taken
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
idex_en  out  1  ID/EX register enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  load NOP into ID/EX
exmem_bubble  out  1  load NOP into EX/MEM
mul_busy  out  1  high while in MUL state
stall_count  out  CNT_W  cycles with pc_en=0, saturating
flush_count  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Reset: asynchronous. State=RUN, mul_cnt=0, stall_count=0, flush_count=0. While rst=1, all outputs hold idle values regardless of inputs: pc_en=ifid_en=idex_en=1, ifid_flush=idex_bubble=exmem_bubble=0, mul_busy=0. Reset mid-multiply aborts it immediately.
- Register 0 is an ordinary register, matching the forwarding unit. There is no zero-register exclusion.
- Control outputs are combinational from state, mul_cnt and the current inputs (Mealy). Only state, mul_cnt and the counters are registered.
- States: RUN, MUL.
- Priority in RUN, highest first:
  1. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1, idex_en=1. flush_count+1. Stay in RUN. Branch overrides load-use and ex_is_mul.
  2. ex_is_mul: pc_en=ifid_en=idex_en=0, exmem_bubble=1. Load mul_cnt=1, go to MUL.
  3. Load-use, i.e. ex_mem_read && ((id_use_a && id_ra==ex_rd) || (id_use_b && id_rb==ex_rd)): pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1. Lasts one cycle only; the condition clears once the load advances to MEM.
  4. Otherwise: idle values.
- MUL state:
  - If mul_cnt == MUL_CYCLES-1: release cycle. Idle outputs, mul_cnt=0, go to RUN.
  - Else: same stall outputs as RUN priority 2, and mul_cnt+1.
  - mul_busy=1 throughout MUL.
  - ex_branch_taken, ex_mem_read and id_* inputs are ignored in MUL.
- Multiply timing: EX occupancy is exactly MUL_CYCLES cycles, of which MUL_CYCLES-1 are stall cycles. A back-to-back multiply arriving in EX after the release cycle retriggers normally from RUN.
- Counters:
  - stall_count increments on every non-reset cycle with pc_en=0.
  - flush_count increments on every RUN cycle with ex_branch_taken=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- mul_cnt width is clog2(MUL_CYCLES)+1 bits.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_use_a=1, id_ra=3 for 1 cycle, then ex_mem_read=0 -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_count=1.
- No false stall: ex_mem_read=1, ex_rd=3, id_ra=3 but id_use_a=0, id_use_b=0 -> idle outputs; stall_count unchanged.
- Multiply, MUL_CYCLES=4: hold ex_is_mul=1 -> 3 stall cycles (exmem_bubble=1, mul_busy=1 on the 2nd and 3rd), 4th cycle idle, state back to RUN; stall_count=3. Second consecutive multiply -> another 3 stalls, stall_count=6.
- Branch vs hazards: ex_branch_taken=1 with ex_is_mul=1 and a load-use match in the same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1, no MUL entry; flush_count=1.
- Reset mid-multiply: assert rst asynchronously on the 2nd MUL cycle -> outputs go idle without waiting for clk; mul_busy=0, counters=0. After release with ex_is_mul=0, no residual stall.
- Saturation with CNT_W=2: 5 load-use stalls -> stall_count sticks at 3.
